// File: rtl/fv_info_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fv_info_rd_arbiter_pkg
// Shared definitions for the FV info SRAM read arbiter: FSM state type and
// default geometry (4 PEs, 128 x 8 bank).
// ---------------------------------------------------------------------------
package fv_info_rd_arbiter_pkg;

  localparam int DEF_NUM_PE = 4;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_RESP = 2'd3
  } fv_arb_state_t;

endpackage

// File: rtl/fv_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fv_rr_arbiter
// Combinational round-robin picker: scans req_i starting at ptr_i and wrapping
// modulo N; the first set bit wins.
// Ports:
//   req_i     [N]        request vector
//   ptr_i     [clog2 N]  index where the search starts
//   gnt_o     [N]        one-hot grant (all zero when no request)
//   gnt_idx_o [clog2 N]  binary index of the grant
// ---------------------------------------------------------------------------
module fv_rr_arbiter
  import fv_info_rd_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_PE
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] sel;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      sel = IW'((int'(ptr_i) + k) % N);
      if (!found && req_i[sel]) begin
        found      = 1'b1;
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/fv_info_rd_arbiter.sv
// ---------------------------------------------------------------------------
// fv_info_rd_arbiter
// Arbitrates NUM_PE read requesters onto one FV info SRAM port. One read is
// in flight at a time: IDLE (accept) -> READ (CEN low) -> CAPT (register Q)
// -> RESP (hold response until the FV FIFO takes it).
// Build option: FV_INFO_ARB_FIXED_PRIO_EN selects fixed priority (lowest
// index wins, no last-grant pointer); default is round-robin.
// Ports:
//   clk, reset         clock, async active-high reset
//   req_valid/req_addr per-PE request and packed address
//   req_ready          one-hot accept, only ever high in IDLE
//   sram_cen/sram_a    SRAM enable (active-low) and address
//   sram_q             SRAM data, valid the cycle after CEN low
//   rsp_valid/rsp_pe_id/rsp_data/rsp_ready  response toward the FV FIFO
// ---------------------------------------------------------------------------
module fv_info_rd_arbiter
  import fv_info_rd_arbiter_pkg::*;
#(
  parameter int NUM_PE = DEF_NUM_PE,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PE-1:0]         req_valid,
  input  logic [NUM_PE*ADDR_W-1:0]  req_addr,
  output logic [NUM_PE-1:0]         req_ready,
  output logic                      sram_cen,
  output logic [ADDR_W-1:0]         sram_a,
  input  logic [DATA_W-1:0]         sram_q,
  output logic                      rsp_valid,
  output logic [$clog2(NUM_PE)-1:0] rsp_pe_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
);

  localparam int ID_W = $clog2(NUM_PE);

  fv_arb_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_sel;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   rsp_pe_id_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [NUM_PE-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              accept;

`ifdef FV_INFO_ARB_FIXED_PRIO_EN
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (!found && req_valid[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] rr_ptr;

  assign rr_ptr = (last_grant_q == ID_W'(NUM_PE - 1)) ? '0 : last_grant_q + 1'b1;
  assign last_grant_d = accept ? grant_idx : last_grant_q;

  fv_rr_arbiter #(.N(NUM_PE)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr),
    .gnt_o     (grant),
    .gnt_idx_o (grant_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_grant_q <= ID_W'(NUM_PE - 1);
    else       last_grant_q <= last_grant_d;
  end
`endif

  // grant is one-hot, so an OR of masked slices selects the winner's address
  always_comb begin
    addr_sel = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      if (grant[k]) addr_sel = addr_sel | req_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // reset is in the accept term so req_ready is low while reset is held,
  // even though IDLE would otherwise grant combinationally
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    sram_cen  = 1'b1;
    sram_a    = '0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid && !reset) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_READ: begin
        sram_cen = 1'b0;
        sram_a   = addr_q;
        state_d  = ST_CAPT;
      end
      ST_CAPT: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      id_q        <= '0;
      rsp_pe_id_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= addr_sel;
        id_q   <= grant_idx;
      end
      if (state_q == ST_CAPT) begin
        rsp_data_q  <= sram_q;
        rsp_pe_id_q <= id_q;
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_pe_id = rsp_pe_id_q;

endmodule

// File: tb/tb_fv_info_rd_arbiter.sv
module tb_fv_info_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [27:0] req_addr;
  logic [3:0]  req_ready;
  logic        sram_cen;
  logic [6:0]  sram_a;
  logic [7:0]  sram_q;
  logic        rsp_valid;
  logic [1:0]  rsp_pe_id;
  logic [7:0]  rsp_data;
  logic        rsp_ready;

  logic [7:0]  mem [128];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fv_info_rd_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .sram_cen  (sram_cen),
    .sram_a    (sram_a),
    .sram_q    (sram_q),
    .rsp_valid (rsp_valid),
    .rsp_pe_id (rsp_pe_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  // SRAM model: data appears the cycle after the CEN-low cycle
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  typedef struct {
    logic [3:0] valid;
    logic [6:0] base;
    int         exp_rr;
    int         exp_fp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] addrs(input logic [6:0] base);
    logic [27:0] a;
    for (int i = 0; i < 4; i++) a[i*7 +: 7] = base + 7'(i);
    return a;
  endfunction

  function automatic int oh2idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return -1;
  endfunction

  function automatic int exp_pe(input vec_t v);
`ifdef FV_INFO_ARB_FIXED_PRIO_EN
    return v.exp_fp;
`else
    return v.exp_rr;
`endif
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // called at a negedge with the DUT in IDLE; returns at a negedge in IDLE
  task automatic run_txn(input logic [3:0] valid, input logic [6:0] base, input int pe);
    logic [6:0] ea;
    ea = base + 7'(pe);
    req_valid = valid;
    req_addr  = addrs(base);
    #1;
    chk("accept_ready", 32'(req_ready), 32'(4'b0001 << pe));
    @(negedge clk);
    req_valid = '0;
    chk("read_cen", 32'(sram_cen), 32'd0);
    chk("read_addr", 32'(sram_a), 32'(ea));
    @(negedge clk);
    chk("capt_cen", 32'(sram_cen), 32'd1);
    chk("capt_addr", 32'(sram_a), 32'd0);
    chk("capt_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("resp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_data", 32'(rsp_data), 32'(mem[ea]));
    chk("resp_pe_id", 32'(rsp_pe_id), 32'(pe));
    @(negedge clk);
    chk("after_resp_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_pe[$];
    int acc_cyc[$];
    int exp_order[5];

    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 7 + 8'h31);
    mem[5] = 8'hA7;

    // round-robin expectation assumes the sequence starts right after reset
    vecs[0] = '{4'b0010, 7'h04, 1, 1};
    vecs[1] = '{4'b1111, 7'h10, 2, 0};
    vecs[2] = '{4'b0011, 7'h20, 0, 0};
    vecs[3] = '{4'b1001, 7'h30, 3, 0};
    vecs[4] = '{4'b1001, 7'h40, 0, 0};
    vecs[5] = '{4'b0001, 7'h50, 0, 0};
    vecs[6] = '{4'b1100, 7'h60, 2, 2};
    vecs[7] = '{4'b0100, 7'h7D, 2, 2};

    reset = 1'b1; req_valid = 4'b1111; req_addr = '0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_cen", 32'(sram_cen), 32'd1);
    chk("rst_addr", 32'(sram_a), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_pe_id", 32'(rsp_pe_id), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    do_reset();

    // idle with no requests
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_cen", 32'(sram_cen), 32'd1);
      @(negedge clk);
    end

    for (int v = 0; v < 8; v++) run_txn(vecs[v].valid, vecs[v].base, exp_pe(vecs[v]));

    // continuous requesters: grant order and 4-cycle accept spacing
    do_reset();
`ifdef FV_INFO_ARB_FIXED_PRIO_EN
    req_valid = 4'b0101;
    exp_order = '{0, 0, 0, 0, 0};
`else
    req_valid = 4'b1111;
    exp_order = '{0, 1, 2, 3, 0};
`endif
    req_addr = addrs(7'h08);
    for (int c = 0; c < 20; c++) begin
      #1;
      if (|req_ready) begin
        acc_pe.push_back(oh2idx(req_ready));
        acc_cyc.push_back(c);
      end
      @(negedge clk);
    end
    req_valid = '0;
    chk("cont_accept_count", 32'(acc_pe.size()), 32'd5);
    for (int i = 0; i < 5 && i < acc_pe.size(); i++) begin
      chk("cont_grant_pe", 32'(acc_pe[i]), 32'(exp_order[i]));
      chk("cont_accept_cycle", 32'(acc_cyc[i]), 32'(4 * i));
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // backpressure: 10-cycle stall in RESP with all PEs requesting
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_addr  = addrs(7'h0A);
    #1;
    chk("bp_accept", 32'(req_ready), 32'b0100);
    @(negedge clk);
    req_valid = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'(mem[7'h0C]));
      chk("bp_rsp_pe_id", 32'(rsp_pe_id), 32'd2);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      if (c == 4) req_valid = 4'b0000;
      if (c == 6) req_valid = 4'b1011;
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_no_duplicate", 32'(rsp_valid), 32'd0);
    end

    // reset while in CAPT: no response, next grant to lowest valid PE
    req_valid = 4'b1000;
    req_addr  = addrs(7'h14);
    #1;
    chk("capt_rst_accept", 32'(req_ready), 32'b1000);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("capt_rst_in_capt", 32'(sram_cen), 32'd1);
    reset = 1'b1;
    req_valid = 4'b0110;
    #1;
    chk("capt_rst_ready", 32'(req_ready), 32'd0);
    chk("capt_rst_cen", 32'(sram_cen), 32'd1);
    chk("capt_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("capt_rst_data", 32'(rsp_data), 32'd0);
    chk("capt_rst_pe_id", 32'(rsp_pe_id), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("capt_rst_no_rsp", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    run_txn(4'b0110, 7'h1E, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
